// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

    localparam logic OVL_ON    = 1'b1;
    localparam logic OVL_OFF   = 1'b0;
    localparam logic OUT_MEALY = 1'b0;
    localparam logic OUT_MOORE = 1'b1;

    // Legal pattern lengths are 2..pat_w; anything outside is pulled to the nearest bound.
    function automatic int clamp_len(int len, int pat_w);
        if (len < 2)
            return 2;
        if (len > pat_w)
            return pat_w;
        return len;
    endfunction

endpackage

// File: rtl/seq_det_if.sv
// Configuration, serial input and status bundle for seq_det_param.
interface seq_det_if #(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W) + 1,
    parameter int CNT_W = 8
);
    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pat;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_ovl;
    logic             cfg_moore;
    logic             x_valid;
    logic             x;
    logic             y;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    modport master (
        output cfg_we, cfg_pat, cfg_len, cfg_ovl, cfg_moore, x_valid, x,
        input  y, match_cnt, cnt_sat
    );

    modport slave (
        input  cfg_we, cfg_pat, cfg_len, cfg_ovl, cfg_moore, x_valid, x,
        output y, match_cnt, cnt_sat
    );
endinterface

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter; clr wins over inc, count holds at all-ones.
module seq_det_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sat
);
    assign sat = &cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc && !sat)
            cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
    end
endmodule

// File: rtl/seq_det_param.sv
// Runtime-configurable serial bit-pattern detector with overlap/Moore modes and match counter.
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W     = 8,
    parameter int               LEN_W     = $clog2(PAT_W) + 1,
    parameter int               CNT_W     = 8,
    parameter logic [PAT_W-1:0] DEF_PAT   = PAT_W'(8'b0000_0101),
    parameter int               DEF_LEN   = 3,
    parameter logic             DEF_OVL   = OVL_ON,
    parameter logic             DEF_MOORE = OUT_MEALY
) (
    input logic clk,
    input logic rst,
    seq_det_if.slave bus
);
    localparam logic [LEN_W-1:0] DEF_LEN_C = LEN_W'(clamp_len(DEF_LEN, PAT_W));

    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic             ovl_q;
    logic             moore_q;
    // Only the PAT_W-1 most recent bits are ever compared; the live x supplies the last one.
    logic [PAT_W-2:0] hist;
    logic [LEN_W-1:0] fill;
    logic             y_q;

    logic [PAT_W-1:0] win;
    logic [PAT_W-1:0] mask;
    logic [LEN_W:0]   fill_p1;
    logic [LEN_W-1:0] fill_nxt;
    logic             sample;
    logic             armed;
    logic             hit;

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++)
            mask[i] = (i < int'(len_q));
    end

    assign win     = {hist, bus.x};
    assign fill_p1 = {1'b0, fill} + {{LEN_W{1'b0}}, 1'b1};
    assign armed   = fill_p1 >= {1'b0, len_q};
    assign sample  = bus.x_valid & ~bus.cfg_we & ~rst;
    assign hit     = sample & armed & ((win & mask) == (pat_q & mask));

    // Non-overlap restarts acquisition after a hit; otherwise fill saturates at len (armed).
    always_comb begin
        fill_nxt = fill_p1[LEN_W-1:0];
        if (hit && ovl_q == OVL_OFF)
            fill_nxt = '0;
        else if (fill == len_q)
            fill_nxt = fill;
    end

    assign bus.y = ~rst & ~bus.cfg_we & ((moore_q == OUT_MOORE) ? y_q : hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q   <= DEF_PAT;
            len_q   <= DEF_LEN_C;
            ovl_q   <= DEF_OVL;
            moore_q <= DEF_MOORE;
            hist    <= '0;
            fill    <= '0;
            y_q     <= 1'b0;
        end else if (bus.cfg_we) begin
            pat_q   <= bus.cfg_pat;
            len_q   <= LEN_W'(clamp_len(int'(bus.cfg_len), PAT_W));
            ovl_q   <= bus.cfg_ovl;
            moore_q <= bus.cfg_moore;
            hist    <= '0;
            fill    <= '0;
            y_q     <= 1'b0;
        end else begin
            y_q <= hit;
            if (bus.x_valid) begin
                hist <= win[PAT_W-2:0];
                fill <= fill_nxt;
            end
        end
    end

    seq_det_sat_cnt #(.W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit),
        .clr (bus.cfg_we),
        .cnt (bus.match_cnt),
        .sat (bus.cnt_sat)
    );
endmodule
